// File: rtl/am_align_ctrl.sv
// Multi-lane alignment controller: validates the lane-ID permutation, measures
// marker skew, programs per-lane deskew delays and monitors alignment while locked.
module am_align_ctrl #(
    parameter int unsigned LANE_N   = 4,
    parameter int unsigned LANE_W   = $clog2(LANE_N),
    parameter int unsigned MAX_SKEW = 15,
    parameter int unsigned SKEW_W   = $clog2(MAX_SKEW + 1),
    parameter int unsigned BAD_N    = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     valid_i,
    input  logic [LANE_N-1:0]        lock_v_i,
    input  logic [LANE_N-1:0]        am_v_i,
    input  logic [LANE_N*LANE_N-1:0] lane_id_i,
    output logic                     align_v_o,
    output logic [LANE_N*LANE_W-1:0] map_o,
    output logic [LANE_N*SKEW_W-1:0] delay_o,
    output logic                     restart_o
);

    localparam int unsigned CNT_W = SKEW_W + 1;
    localparam int unsigned BAD_W = $clog2(BAD_N + 1);

    typedef enum logic [1:0] {
        WAIT_LOCK,
        CHECK_MAP,
        DESKEW,
        ALIGNED
    } state_t;

    state_t                     state, state_nxt;
    logic                       align_nxt;
    logic [LANE_N*LANE_W-1:0]   map_nxt;
    logic [LANE_N*SKEW_W-1:0]   delay_nxt;
    logic                       restart_nxt;
    logic [BAD_W-1:0]           bad_cnt, bad_cnt_nxt;
    logic [CNT_W-1:0]           skew_cnt, skew_nxt;
    logic [LANE_N-1:0]          arrived, arrived_nxt;
    logic [LANE_N*SKEW_W-1:0]   offset, offset_nxt;

    logic                       lock_ok;
    logic [CNT_W-1:0]           skew_inc;
    logic                       round_done;
    logic                       round_bad;
    logic                       id_ok;
    logic                       id_onehot;
    logic [LANE_N-1:0]          id_or;
    logic [LANE_N*LANE_W-1:0]   map_enc;
    logic [SKEW_W-1:0]          max_off;
    logic [LANE_N*SKEW_W-1:0]   calc_delay;

    assign lock_ok  = valid_i && (&lock_v_i);
    // Saturates one past MAX_SKEW so the overflow compare never wraps.
    assign skew_inc = (skew_cnt > CNT_W'(MAX_SKEW)) ? skew_cnt : skew_cnt + CNT_W'(1);

    // Lane-ID permutation check and one-hot to binary encode.
    always_comb begin
        id_or     = '0;
        id_onehot = 1'b1;
        map_enc   = '0;
        for (int p = 0; p < LANE_N; p++) begin
            id_or = id_or | lane_id_i[p*LANE_N +: LANE_N];
            if ($countones(lane_id_i[p*LANE_N +: LANE_N]) != 1) begin
                id_onehot = 1'b0;
            end
            for (int l = 0; l < LANE_N; l++) begin
                if (lane_id_i[p*LANE_N + l]) begin
                    map_enc[p*LANE_W +: LANE_W] = LANE_W'(l);
                end
            end
        end
        id_ok = id_onehot && (&id_or);
    end

    // Delay per lane is the gap to the latest arrival of the finished round.
    always_comb begin
        max_off    = '0;
        calc_delay = '0;
        for (int p = 0; p < LANE_N; p++) begin
            if (offset[p*SKEW_W +: SKEW_W] > max_off) begin
                max_off = offset[p*SKEW_W +: SKEW_W];
            end
        end
        for (int p = 0; p < LANE_N; p++) begin
            calc_delay[p*SKEW_W +: SKEW_W] = max_off - offset[p*SKEW_W +: SKEW_W];
        end
    end

    // Next-state, round tracking and registered output values.
    always_comb begin
        state_nxt   = state;
        align_nxt   = align_v_o;
        map_nxt     = map_o;
        delay_nxt   = delay_o;
        restart_nxt = 1'b0;
        bad_cnt_nxt = bad_cnt;
        skew_nxt    = skew_cnt;
        arrived_nxt = arrived;
        offset_nxt  = offset;
        round_done  = 1'b0;
        round_bad   = 1'b0;

        // A completed round is evaluated one cycle after its last arrival;
        // markers in that cycle open the next round.
        if (&arrived) begin
            round_done  = 1'b1;
            arrived_nxt = am_v_i;
            skew_nxt    = '0;
            offset_nxt  = '0;
        end else if (|arrived) begin
            if ((|(am_v_i & arrived)) || (skew_inc > CNT_W'(MAX_SKEW))) begin
                round_bad   = 1'b1;
                arrived_nxt = '0;
                skew_nxt    = '0;
                offset_nxt  = '0;
            end else begin
                skew_nxt = skew_inc;
                for (int p = 0; p < LANE_N; p++) begin
                    if (am_v_i[p]) begin
                        offset_nxt[p*SKEW_W +: SKEW_W] = skew_inc[SKEW_W-1:0];
                    end
                end
                arrived_nxt = arrived | am_v_i;
            end
        end else begin
            arrived_nxt = am_v_i;
            skew_nxt    = '0;
            offset_nxt  = '0;
        end

        if ((state != WAIT_LOCK) && !lock_ok) begin
            state_nxt   = WAIT_LOCK;
            align_nxt   = 1'b0;
            bad_cnt_nxt = '0;
            arrived_nxt = '0;
            skew_nxt    = '0;
            offset_nxt  = '0;
        end else begin
            case (state)
                WAIT_LOCK: begin
                    align_nxt   = 1'b0;
                    bad_cnt_nxt = '0;
                    arrived_nxt = '0;
                    skew_nxt    = '0;
                    offset_nxt  = '0;
                    if (lock_ok) begin
                        state_nxt = CHECK_MAP;
                    end
                end
                CHECK_MAP: begin
                    arrived_nxt = '0;
                    skew_nxt    = '0;
                    offset_nxt  = '0;
                    if (id_ok) begin
                        map_nxt   = map_enc;
                        state_nxt = DESKEW;
                    end else begin
                        restart_nxt = 1'b1;
                        state_nxt   = WAIT_LOCK;
                    end
                end
                DESKEW: begin
                    if (round_done) begin
                        delay_nxt   = calc_delay;
                        align_nxt   = 1'b1;
                        bad_cnt_nxt = '0;
                        state_nxt   = ALIGNED;
                    end else if (round_bad) begin
                        restart_nxt = 1'b1;
                        state_nxt   = WAIT_LOCK;
                    end
                end
                ALIGNED: begin
                    if ((round_done && (calc_delay != delay_o)) || round_bad) begin
                        if (bad_cnt == BAD_W'(BAD_N - 1)) begin
                            restart_nxt = 1'b1;
                            align_nxt   = 1'b0;
                            bad_cnt_nxt = '0;
                            state_nxt   = WAIT_LOCK;
                            arrived_nxt = '0;
                            skew_nxt    = '0;
                            offset_nxt  = '0;
                        end else begin
                            bad_cnt_nxt = bad_cnt + BAD_W'(1);
                        end
                    end else if (round_done) begin
                        bad_cnt_nxt = '0;
                    end
                end
                default: begin
                    state_nxt = WAIT_LOCK;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= WAIT_LOCK;
            align_v_o <= 1'b0;
            map_o     <= '0;
            delay_o   <= '0;
            restart_o <= 1'b0;
            bad_cnt   <= '0;
            skew_cnt  <= '0;
            arrived   <= '0;
            offset    <= '0;
        end else begin
            state     <= state_nxt;
            align_v_o <= align_nxt;
            map_o     <= map_nxt;
            delay_o   <= delay_nxt;
            restart_o <= restart_nxt;
            bad_cnt   <= bad_cnt_nxt;
            skew_cnt  <= skew_nxt;
            arrived   <= arrived_nxt;
            offset    <= offset_nxt;
        end
    end

endmodule

// File: tb/tb_am_align_ctrl.sv
// Directed-vector bench for am_align_ctrl with hand-computed expectations.
module tb_am_align_ctrl;

    localparam logic [15:0] ID_IDENT = 16'h8421;
    localparam logic [15:0] ID_DUP   = 16'h8441;
    localparam logic [7:0]  MAP_IDENT = 8'hE4;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid;
    logic [3:0]  lock_v;
    logic [3:0]  am_v;
    logic [15:0] lane_id;
    logic        align_v;
    logic [7:0]  map;
    logic [15:0] delay;
    logic        restart;

    int n_vec = 0;
    int n_err = 0;

    am_align_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .valid_i   (valid),
        .lock_v_i  (lock_v),
        .am_v_i    (am_v),
        .lane_id_i (lane_id),
        .align_v_o (align_v),
        .map_o     (map),
        .delay_o   (delay),
        .restart_o (restart)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        valid  = 1'b0;
        lock_v = 4'h0;
        am_v   = 4'h0;
        tick();
        reset  = 1'b0;
    endtask

    // Two edges: WAIT_LOCK -> CHECK_MAP -> DESKEW.
    task automatic acquire();
        valid  = 1'b1;
        lock_v = 4'hF;
        tick();
        tick();
    endtask

    // Marker on lane p at round offset op; returns right after the last arrival edge.
    task automatic run_round(input int o0, input int o1, input int o2, input int o3);
        int mx;
        mx = o0;
        if (o1 > mx) mx = o1;
        if (o2 > mx) mx = o2;
        if (o3 > mx) mx = o3;
        for (int t = 0; t <= mx; t++) begin
            am_v = {o3 == t, o2 == t, o1 == t, o0 == t};
            tick();
        end
        am_v = 4'h0;
    endtask

    initial begin
        reset   = 1'b1;
        valid   = 1'b0;
        lock_v  = 4'h0;
        am_v    = 4'h0;
        lane_id = ID_IDENT;
        tick();
        tick();
        check_eq("rst_align", 32'(align_v), 32'h0);
        check_eq("rst_map", 32'(map), 32'h0);
        check_eq("rst_delay", 32'(delay), 32'h0);
        check_eq("rst_restart", 32'(restart), 32'h0);
        reset = 1'b0;

        // Identity map, all markers in one cycle
        acquire();
        check_eq("t1_map", 32'(map), 32'(MAP_IDENT));
        check_eq("t1_align_pre", 32'(align_v), 32'h0);
        run_round(0, 0, 0, 0);
        check_eq("t1_align_1cyc", 32'(align_v), 32'h0);
        tick();
        check_eq("t1_align_2cyc", 32'(align_v), 32'h1);
        check_eq("t1_delay", 32'(delay), 32'h0);

        // Skewed arrival 0,3,7,2
        do_reset();
        acquire();
        run_round(0, 3, 7, 2);
        check_eq("t2_align_pre", 32'(align_v), 32'h0);
        tick();
        check_eq("t2_delay", 32'(delay), 32'h5047);
        check_eq("t2_align", 32'(align_v), 32'h1);

        // Duplicate lane ID
        lock_v = 4'h0;
        tick();
        check_eq("t3_drop_align", 32'(align_v), 32'h0);
        check_eq("t3_drop_restart", 32'(restart), 32'h0);
        lane_id = ID_DUP;
        lock_v  = 4'hF;
        tick();
        check_eq("t3_restart_early", 32'(restart), 32'h0);
        tick();
        check_eq("t3_restart", 32'(restart), 32'h1);
        check_eq("t3_align", 32'(align_v), 32'h0);
        check_eq("t3_map_kept", 32'(map), 32'(MAP_IDENT));
        lock_v = 4'h0;
        tick();
        check_eq("t3_restart_end", 32'(restart), 32'h0);
        lane_id = ID_IDENT;

        // Excess skew: lane 3 at offset 16
        do_reset();
        acquire();
        run_round(0, 0, 0, 16);
        check_eq("t4_restart", 32'(restart), 32'h1);
        check_eq("t4_align", 32'(align_v), 32'h0);
        check_eq("t4_delay", 32'(delay), 32'h0);
        lock_v = 4'h0;
        tick();
        check_eq("t4_restart_end", 32'(restart), 32'h0);
        // Offset 15 is still inside the window
        acquire();
        run_round(0, 0, 0, 15);
        tick();
        check_eq("t4_max_delay", 32'(delay), 32'h0FFF);
        check_eq("t4_max_align", 32'(align_v), 32'h1);

        // Three consecutive bad rounds force a relock
        do_reset();
        acquire();
        run_round(0, 0, 0, 0);
        tick();
        check_eq("t5_align0", 32'(align_v), 32'h1);
        run_round(0, 0, 1, 0);
        tick();
        check_eq("t5_bad1_align", 32'(align_v), 32'h1);
        run_round(0, 0, 1, 0);
        tick();
        check_eq("t5_bad2_align", 32'(align_v), 32'h1);
        check_eq("t5_bad2_restart", 32'(restart), 32'h0);
        check_eq("t5_bad2_delay", 32'(delay), 32'h0);
        run_round(0, 0, 1, 0);
        tick();
        check_eq("t5_bad3_restart", 32'(restart), 32'h1);
        check_eq("t5_bad3_align", 32'(align_v), 32'h0);
        lock_v = 4'h0;
        tick();
        check_eq("t5_restart_end", 32'(restart), 32'h0);

        // A good round in between clears the bad count
        acquire();
        run_round(0, 0, 0, 0);
        tick();
        run_round(0, 0, 1, 0);
        tick();
        run_round(0, 0, 0, 0);
        tick();
        run_round(0, 0, 1, 0);
        tick();
        run_round(0, 0, 1, 0);
        tick();
        check_eq("t5v_align", 32'(align_v), 32'h1);
        check_eq("t5v_restart", 32'(restart), 32'h0);
        run_round(0, 0, 0, 0);
        tick();
        check_eq("t5v_good_align", 32'(align_v), 32'h1);
        check_eq("t5v_delay", 32'(delay), 32'h0);

        // Lock drop on lane 1 for one cycle, then full reacquisition
        lock_v = 4'b1101;
        tick();
        check_eq("t6_align", 32'(align_v), 32'h0);
        check_eq("t6_restart", 32'(restart), 32'h0);
        lock_v = 4'hF;
        tick();
        check_eq("t6_check_restart", 32'(restart), 32'h0);
        tick();
        run_round(0, 3, 7, 2);
        check_eq("t6_align_pre", 32'(align_v), 32'h0);
        tick();
        check_eq("t6_align", 32'(align_v), 32'h1);
        check_eq("t6_delay", 32'(delay), 32'h5047);

        // Async reset in the middle of a DESKEW round
        lock_v = 4'h0;
        tick();
        lock_v = 4'hF;
        tick();
        tick();
        am_v = 4'b0001;
        tick();
        am_v = 4'h0;
        tick();
        check_eq("t7_map_before", 32'(map), 32'(MAP_IDENT));
        check_eq("t7_delay_before", 32'(delay), 32'h5047);
        #2;
        reset = 1'b1;
        #1;
        check_eq("t7_align", 32'(align_v), 32'h0);
        check_eq("t7_map", 32'(map), 32'h0);
        check_eq("t7_delay", 32'(delay), 32'h0);
        check_eq("t7_restart", 32'(restart), 32'h0);
        tick();
        reset = 1'b0;
        acquire();
        run_round(1, 0, 0, 0);
        tick();
        check_eq("t7_reacq_align", 32'(align_v), 32'h1);
        check_eq("t7_reacq_delay", 32'(delay), 32'h1110);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule

// File: doc/am_align_ctrl.md
Name: am_align_ctrl

Overview:
- Multi-lane alignment controller. It sits after the per-lane alignment-marker lock units and before the deskew FIFOs / lane reorder mux.
- It waits until every physical lane reports marker lock, then checks that the lane IDs form a permutation and builds the logical-lane map.
- It measures inter-lane marker skew, programs per-lane delays, and raises global alignment status.
- While aligned it keeps monitoring: it re-measures skew on every marker round and requests a relock when alignment is lost.

Parameters:
- LANE_N, 4, number of physical lanes.
- LANE_W, $clog2(LANE_N) = 2, width of a binary logical-lane index.
- MAX_SKEW, 15, largest tolerated arrival spread in valid cycles.
- SKEW_W, $clog2(MAX_SKEW+1) = 4, width of skew counter and delay fields.
- BAD_N, 3, number of consecutive bad marker rounds that forces a relock.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous reset, active high.
- valid_i  in  1  datapath valid this cycle; all counters advance only on valid_i.
- lock_v_i  in  LANE_N  per-lane marker lock status.
- am_v_i  in  LANE_N  per-lane pulse: alignment marker detected this cycle.
- lane_id_i  in  LANE_N*LANE_N  per physical lane p, bits [p*LANE_N +: LANE_N] carry the one-hot logical lane ID.
- align_v_o  out  1  all lanes locked, mapped and deskewed.
- map_o  out  LANE_N*LANE_W  binary logical index per physical lane.
- delay_o  out  LANE_N*SKEW_W  per-lane delay in valid cycles to apply in deskew.
- restart_o  out  1  one-cycle pulse requesting all lock units to resync.

Behaviour:
- Reset values: state=WAIT_LOCK; align_v_o=0; map_o=0; delay_o=0; restart_o=0; bad_cnt=0; skew_cnt=0; all arrival flags cleared.
- All outputs are registered. align_v_o changes one cycle after the causing input.
- States: WAIT_LOCK, CHECK_MAP, DESKEW, ALIGNED.
- Any state other than WAIT_LOCK, on valid_i=0 or any lock_v_i bit low: go to WAIT_LOCK, clear align_v_o next cycle, no restart_o. This has priority over every other transition.
- WAIT_LOCK: when valid_i and &lock_v_i, go to CHECK_MAP.
- CHECK_MAP (single cycle):
  - Each lane ID must be exactly one-hot, and the OR of all IDs must be all-ones (no duplicates).
  - Pass: latch map_o as the binary encode of each ID, then go to DESKEW.
  - Fail: pulse restart_o, go to WAIT_LOCK.
- DESKEW round, used both for the initial measurement and for every round while aligned:
  - Idle until the first cycle with valid_i and |am_v_i. That cycle sets skew_cnt=0 and records offset 0 for every lane whose am_v_i is high.
  - On each following valid cycle, skew_cnt increments. A lane's first am_v_i records offset=skew_cnt.
  - A second am_v_i on an already-arrived lane within the round makes the round bad.
  - If skew_cnt would exceed MAX_SKEW with any lane missing, the round is bad.
  - The round completes when all lanes have arrived; then delay[p] = max_offset - offset[p].
- DESKEW outcome:
  - Good round: load delay_o, go to ALIGNED, set align_v_o.
  - Bad round: pulse restart_o, go to WAIT_LOCK.
- ALIGNED: keep align_v_o=1, map_o and delay_o stable, and run a new round on each marker period.
  - Round good and computed delays equal delay_o: bad_cnt=0.
  - Round bad or delays differ: bad_cnt+1. delay_o is never updated while aligned.
  - When bad_cnt reaches BAD_N: pulse restart_o, clear align_v_o, go to WAIT_LOCK, and reset bad_cnt to 0.
- While the lock status holds, map_o is not re-evaluated; a lane-ID change is caught by the lock units dropping lock.
- Simultaneous events:
  - Lock drop in the same cycle as round completion: the lock drop wins, and no restart_o pulse is issued.
  - am_v_i while valid_i=0 is ignored.
- Asynchronous reset mid-round discards partial offsets immediately.
- Arithmetic: skew_cnt saturates at MAX_SKEW+1 (used only for the overflow test). delay is an unsigned SKEW_W-bit value and never underflows, because max_offset >= offset.

Test Plan:
- Reset, then assert all locks with IDs identity (lane p -> ID 1<<p) and drive am_v_i=4'b1111 in one cycle.
  - Expect: map_o = {3,2,1,0} packed; delay_o all 0; align_v_o=1 two cycles after the AM cycle.
- Skewed arrival: lanes 0,1,2,3 arrive at offsets 0,3,7,2.
  - Expect: delay_o = {5,0,4,7} for lanes 3..0; align_v_o rises.
- Duplicate ID: lanes 1 and 2 both report 4'b0100.
  - Expect: single restart_o pulse one cycle after CHECK_MAP; align_v_o stays 0; map_o unchanged.
- Excess skew: lane 3 arrives at offset 16 with MAX_SKEW=15.
  - Expect: restart_o pulse; state returns to WAIT_LOCK; delay_o stays 0.
- Aligned, then 3 consecutive rounds with lane 2 shifted by +1.
  - Expect: align_v_o stays 1 through 2 bad rounds and drops after the 3rd, with one restart_o pulse.
  - Variant: a good round between bad rounds clears bad_cnt, so no restart occurs.
- Aligned, then lock_v_i[1] drops for one cycle.
  - Expect: align_v_o=0 next cycle; no restart_o; once lock returns, full reacquisition via CHECK_MAP and DESKEW.
  - Also: async reset asserted mid-DESKEW clears all outputs in the same cycle.
